ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 94 +++++++++
 tb/tb_ifu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch: FETCH issues imem_req at pc, HOLD keeps the word until advance.
// One-cycle minimum fetch latency; stalls while imem_ready is low, holds instr until advance.
module ifu #(
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter logic [1:0]  NPC_SEL_PC_ADD_4 = 2'b00,
    parameter logic [1:0]  NPC_SEL_BEQ_JMP  = 2'b01,
    parameter logic [1:0]  NPC_SEL_J_JMP    = 2'b10,
    parameter logic [1:0]  NPC_SEL_REG_JMP  = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  npc_sel,
    input  logic [31:0] reg_target,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        misalign_q;
    logic [31:0] br_off;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (npc_sel)
            NPC_SEL_PC_ADD_4: next_pc = pc_plus4;
            NPC_SEL_BEQ_JMP:  next_pc = pc_plus4 + br_off;
            NPC_SEL_J_JMP:    next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
            NPC_SEL_REG_JMP:  next_pc = {reg_target[31:2], 2'b00};
            default:          next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = !rst;
                if (imem_ready) state_d = HOLD;
            end
            HOLD: begin
                if (advance) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_ready) begin
                instr_q       <= imem_rdata;
                instr_valid_q <= 1'b1;
            end
            if (state_q == HOLD && advance) begin
                pc_q          <= next_pc;
                instr_valid_q <= 1'b0;
                // Target is still taken (word-aligned); the flag just records the bad low bits.
                if (npc_sel == NPC_SEL_REG_JMP && reg_target[1:0] != 2'b00)
                    misalign_q <= 1'b1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: reset, sequential fetch, branch, jump, JR misalign, stall, wrap, mid-op reset.
module tb_ifu;

    logic        clk;
    logic        rst;
    logic [1:0]  npc_sel;
    logic [31:0] reg_target;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    ifu dut (
        .clk        (clk),
        .rst        (rst),
        .npc_sel    (npc_sel),
        .reg_target (reg_target),
        .advance    (advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a word with ready high for one edge, then check it is held.
    task automatic fetch(input string tag, input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        advance    = 1'b0;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, word);
    endtask

    task automatic adv(input logic [1:0] sel, input logic [31:0] rt);
        npc_sel    = sel;
        reg_target = rt;
        advance    = 1'b1;
        step();
        advance    = 1'b0;
        npc_sel    = 2'b00;
        reg_target = 32'h0;
    endtask

    initial begin
        rst        = 1'b1;
        npc_sel    = 2'b00;
        reg_target = 32'h0;
        advance    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        step();
        step();
        chk("rst_pc",       pc, 32'h0000_3000);
        chk("rst_instr",    instr, 32'h0);
        chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_req",      {31'b0, imem_req}, 32'd0);

        rst = 1'b0;
        #1;
        chk("req_after_rst", {31'b0, imem_req}, 32'd1);
        chk("addr_after_rst", imem_addr, 32'h0000_3000);

        // Sequential fetch
        fetch("seq0", 32'h1111_0000);
        chk("seq0_req_hold", {31'b0, imem_req}, 32'd0);
        chk("seq0_pc", pc, 32'h0000_3000);
        chk("seq0_pc4", pc_plus4, 32'h0000_3004);
        // imem_ready ignored in HOLD
        imem_ready = 1'b1;
        imem_rdata = 32'h5555_5555;
        step();
        imem_ready = 1'b0;
        chk("hold_ignore_ready", instr, 32'h1111_0000);
        adv(2'b00, 32'h0);
        chk("seq1_pc", pc, 32'h0000_3004);
        chk("seq1_valid", {31'b0, instr_valid}, 32'd0);
        chk("seq1_req", {31'b0, imem_req}, 32'd1);
        fetch("seq1", 32'h2222_0000);
        adv(2'b00, 32'h0);
        chk("seq2_pc", pc, 32'h0000_3008);
        fetch("seq2", 32'h3333_0000);
        adv(2'b00, 32'h0);
        fetch("seq3", 32'h4444_0000);
        adv(2'b00, 32'h0);
        chk("seq4_pc", pc, 32'h0000_3010);

        // Branch backwards: 3010 + 4 - 8
        fetch("beq0", 32'h1000_FFFE);
        adv(2'b01, 32'h0);
        chk("beq_back_pc", pc, 32'h0000_300C);
        fetch("beq1", 32'h0);
        adv(2'b00, 32'h0);
        chk("beq_pre_pc", pc, 32'h0000_3010);
        // Branch forwards: 3010 + 4 + 12
        fetch("beq2", 32'h1000_0003);
        adv(2'b01, 32'h0);
        chk("beq_fwd_pc", pc, 32'h0000_3020);

        // Reset while holding with advance high
        fetch("rst_hold", 32'h7777_7777);
        rst     = 1'b1;
        advance = 1'b1;
        npc_sel = 2'b11;
        reg_target = 32'h0000_8000;
        step();
        chk("midrst_pc", pc, 32'h0000_3000);
        chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst_instr", instr, 32'h0);
        rst     = 1'b0;
        advance = 1'b0;
        npc_sel = 2'b00;
        reg_target = 32'h0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd1);
        chk("midrst_addr", imem_addr, 32'h0000_3000);

        // Jump
        fetch("j", 32'h0800_0C10);
        chk("j_pc4", pc_plus4, 32'h0000_3004);
        adv(2'b10, 32'h0);
        chk("j_pc", pc, 32'h0000_3040);

        // JR misaligned target
        fetch("jr", 32'h0);
        adv(2'b11, 32'h0000_3007);
        chk("jr_pc", pc, 32'h0000_3004);
        chk("jr_misalign", {31'b0, misalign}, 32'd1);
        fetch("jr_next", 32'h0);
        adv(2'b00, 32'h0);
        chk("jr_pc2", pc, 32'h0000_3008);
        chk("misalign_sticky", {31'b0, misalign}, 32'd1);

        // Stall with advance held high
        imem_ready = 1'b0;
        advance    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", {31'b0, imem_req}, 32'd1);
            chk("stall_pc", pc, 32'h0000_3008);
            chk("stall_valid", {31'b0, instr_valid}, 32'd0);
        end
        advance = 1'b0;
        fetch("stall_end", 32'hABCD_0123);

        // Wrap-around of pc + 4
        adv(2'b11, 32'hFFFF_FFFC);
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        fetch("wrap", 32'h0);
        chk("wrap_pc4", pc_plus4, 32'h0000_0000);
        adv(2'b00, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_misalign", {31'b0, misalign}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
